ip_tx_arb: RTL and testbench
============================

Name: ip_tx_arb

Overview:
Packet-level arbiter that shares the single IPv4 TX path (IP input of ip_512) between S_COUNT IP-frame requesters, e.g. RoCE, UDP and ICMP engines.
- Selects one requester by round-robin, forwards its header and locks the payload mux to it until tlast transfers.
- Sits directly upstream of ip_512 s_ip_* ports, on a 512-bit datapath.

Parameters:
S_COUNT, 2, number of requesters (2..8)
DATA_WIDTH, 512, payload tdata width
KEEP_WIDTH, DATA_WIDTH/8, payload tkeep width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_ip_hdr_valid  in  S_COUNT  per-requester header valid
s_ip_hdr_ready  out  S_COUNT  per-requester header ready
s_ip_hdr  in  S_COUNT*HDR_W  packed headers {is_roce,dscp,ecn,length,ttl,protocol,source_ip,dest_ip}, 105 b each
s_ip_payload_axis_tdata  in  S_COUNT*DATA_WIDTH  payload data
s_ip_payload_axis_tkeep  in  S_COUNT*KEEP_WIDTH  payload keep
s_ip_payload_axis_tvalid  in  S_COUNT  payload valid
s_ip_payload_axis_tready  out  S_COUNT  payload ready
s_ip_payload_axis_tlast  in  S_COUNT  payload last
s_ip_payload_axis_tuser  in  S_COUNT  payload error flag
m_ip_hdr_valid  out  1  header valid to ip_512
m_ip_hdr_ready  in  1  header ready from ip_512
m_ip_hdr  out  HDR_W  selected header, registered
m_ip_payload_axis_tdata  out  DATA_WIDTH  muxed data
m_ip_payload_axis_tkeep  out  KEEP_WIDTH  muxed keep
m_ip_payload_axis_tvalid  out  1  muxed valid
m_ip_payload_axis_tready  in  1  downstream ready
m_ip_payload_axis_tlast  out  1  muxed last
m_ip_payload_axis_tuser  out  1  muxed user
m_grant_index  out  max(1,$clog2(S_COUNT))  index of current/last grant
busy  out  1  high while in ACTIVE

Behaviour:
- Reset values:
  - state IDLE; m_ip_hdr_valid 0; m_grant_index 0; busy 0.
  - all s_ip_hdr_ready 0 and all s_ip_payload_axis_tready 0 while rst high.
  - round-robin pointer (last_grant) = S_COUNT-1, so port 0 wins first.
- States: IDLE, ACTIVE.
- IDLE arbitration:
  - selection is combinational: first i with s_ip_hdr_valid[i], searching circularly from last_grant+1.
  - the selected port's s_ip_hdr_ready = 1 in the same cycle (header accepted).
  - on that cycle: m_ip_hdr <= selected header, m_ip_hdr_valid <= 1, grant/last_grant/m_grant_index <= i, state <= ACTIVE.
  - latency s_ip_hdr_valid -> m_ip_hdr_valid is 1 cycle.
  - no valid requester: stay IDLE, all readies 0.
- ACTIVE:
  - header: m_ip_hdr_valid holds until m_ip_hdr_ready, then clears; header must stay stable while valid.
  - payload: m_* payload = granted input combinationally; s_tready[grant] = m_tready; other ports' tready = 0.
  - payload is not gated by header acceptance.
  - all s_ip_hdr_ready = 0.
- Exit ACTIVE -> IDLE when both hold:
  - the granted tlast beat has transferred (sticky flag tlast_done),
  - the header has been accepted (m_ip_hdr_valid 0 or handshaking this cycle).
  - Same-cycle tlast and header handshake exits immediately.
- Back-to-back: the cycle after exit is IDLE arbitration, giving exactly one bubble cycle on the header path.
- Fairness: a requester continuously valid waits at most S_COUNT-1 packets.
- tuser passes through unmodified; the arbiter never drops or truncates packets.
- rst mid-packet: immediate return to reset values; a partially sent packet is abandoned and the downstream owns cleanup.
- busy = (state == ACTIVE).

Optional Feature:
IP_TX_ARB_PRIO_EN:
- Defined: port 0 (RoCE) has strict priority. If s_ip_hdr_valid[0] is high in IDLE, port 0 wins regardless of pointer; other ports use round-robin among themselves, and last_grant updates only on non-zero grants.
- Undefined: pure round-robin across all ports.

Decomposition:
- Package ip_tx_arb_pkg:
  - HDR_W=105 and field offset/width localparams;
  - state encoding (IDLE=1'b0, ACTIVE=1'b1);
  - header pack/unpack functions.
- Sub-module ip_tx_arb_rr_sel: combinational circular priority encoder (request vector, last_grant, prio enable) -> grant valid + index. It is reused by future ARP-request sharing.

Test Plan:
- Single packet, port 1 only, S_COUNT=2: hdr dest_ip 0x0A000002, 3 beats -> m_ip_hdr_valid 1 cycle after request; m_grant_index=1; 3 beats out in order; busy drops the cycle after tlast.
- Both ports valid continuously, 4 packets each -> grants alternate 0,1,0,1...; first grant port 0; one idle header cycle between packets.
- m_ip_hdr_ready held low 5 cycles while port 0's 2-beat payload completes -> state stays ACTIVE until header accepted; no new s_ip_hdr_ready pulse in the meantime.
- Random downstream tready throttling (50%), S_COUNT=4, 200 packets -> outputs byte-identical to per-port scoreboard; no interleaving within a packet.
- Reset asserted mid-payload at beat 2 of 4 -> next cycle all outputs at reset values; a new request on port 1 is then served with port 0 favored order preserved (pointer reset).
- IP_TX_ARB_PRIO_EN defined, ports 0 and 2 always valid, S_COUNT=3 -> port 0 granted every packet; port 2 granted only when port 0 deasserts valid.

Source files
------------

// File: rtl/ip_tx_arb_pkg.sv
// Shared types for the IPv4 TX arbiter: header layout, FSM encoding and header pack/unpack helpers.
package ip_tx_arb_pkg;

   localparam int HDR_W       = 105;

   localparam int DEST_IP_OFF = 0;
   localparam int DEST_IP_W   = 32;
   localparam int SRC_IP_OFF  = 32;
   localparam int SRC_IP_W    = 32;
   localparam int PROTO_OFF   = 64;
   localparam int PROTO_W     = 8;
   localparam int TTL_OFF     = 72;
   localparam int TTL_W       = 8;
   localparam int LEN_OFF     = 80;
   localparam int LEN_W       = 16;
   localparam int ECN_OFF     = 96;
   localparam int ECN_W       = 2;
   localparam int DSCP_OFF    = 98;
   localparam int DSCP_W      = 6;
   localparam int ROCE_OFF    = 104;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   typedef struct packed {
      logic                 is_roce;
      logic [DSCP_W-1:0]    dscp;
      logic [ECN_W-1:0]     ecn;
      logic [LEN_W-1:0]     length;
      logic [TTL_W-1:0]     ttl;
      logic [PROTO_W-1:0]   protocol;
      logic [SRC_IP_W-1:0]  source_ip;
      logic [DEST_IP_W-1:0] dest_ip;
   } ip_hdr_t;

   function automatic ip_hdr_t hdr_unpack(input logic [HDR_W-1:0] v);
      ip_hdr_t h;
      h.is_roce   = v[ROCE_OFF];
      h.dscp      = v[DSCP_OFF +: DSCP_W];
      h.ecn       = v[ECN_OFF +: ECN_W];
      h.length    = v[LEN_OFF +: LEN_W];
      h.ttl       = v[TTL_OFF +: TTL_W];
      h.protocol  = v[PROTO_OFF +: PROTO_W];
      h.source_ip = v[SRC_IP_OFF +: SRC_IP_W];
      h.dest_ip   = v[DEST_IP_OFF +: DEST_IP_W];
      return h;
   endfunction

   function automatic logic [HDR_W-1:0] hdr_pack(input ip_hdr_t h);
      logic [HDR_W-1:0] v;
      v                            = '0;
      v[ROCE_OFF]                  = h.is_roce;
      v[DSCP_OFF +: DSCP_W]        = h.dscp;
      v[ECN_OFF +: ECN_W]          = h.ecn;
      v[LEN_OFF +: LEN_W]          = h.length;
      v[TTL_OFF +: TTL_W]          = h.ttl;
      v[PROTO_OFF +: PROTO_W]      = h.protocol;
      v[SRC_IP_OFF +: SRC_IP_W]    = h.source_ip;
      v[DEST_IP_OFF +: DEST_IP_W]  = h.dest_ip;
      return v;
   endfunction

endpackage

// File: rtl/ip_tx_arb_rr_sel.sv
// Combinational circular priority encoder: first requester after last_grant wins,
// optionally with requester 0 taking strict priority.
module ip_tx_arb_rr_sel #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   input  logic          prio_en,
   output logic          gnt_vld,
   output logic [IW-1:0] gnt_idx
);

   int j;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      j       = 0;
      for (int k = 1; k <= N; k++) begin
         j = int'(last_grant) + k;
         if (j >= N) j = j - N;
         if (!gnt_vld && req[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(j);
         end
      end
      if (prio_en && req[0]) begin
         gnt_vld = 1'b1;
         gnt_idx = '0;
      end
   end

endmodule

// File: rtl/ip_tx_arb.sv
// Packet-level arbiter sharing one IPv4 TX path between S_COUNT requesters.
// Optional strict priority for port 0 via macro IP_TX_ARB_PRIO_EN.
module ip_tx_arb
   import ip_tx_arb_pkg::*;
#(
   parameter int S_COUNT    = 2,
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   localparam int IDX_W     = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [S_COUNT-1:0]            s_ip_hdr_valid,
   output logic [S_COUNT-1:0]            s_ip_hdr_ready,
   input  logic [S_COUNT*HDR_W-1:0]      s_ip_hdr,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
   input  logic [S_COUNT-1:0]            s_ip_payload_axis_tvalid,
   output logic [S_COUNT-1:0]            s_ip_payload_axis_tready,
   input  logic [S_COUNT-1:0]            s_ip_payload_axis_tlast,
   input  logic [S_COUNT-1:0]            s_ip_payload_axis_tuser,
   output logic                          m_ip_hdr_valid,
   input  logic                          m_ip_hdr_ready,
   output logic [HDR_W-1:0]              m_ip_hdr,
   output logic [DATA_WIDTH-1:0]         m_ip_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_ip_payload_axis_tkeep,
   output logic                          m_ip_payload_axis_tvalid,
   input  logic                          m_ip_payload_axis_tready,
   output logic                          m_ip_payload_axis_tlast,
   output logic                          m_ip_payload_axis_tuser,
   output logic [IDX_W-1:0]              m_grant_index,
   output logic                          busy
);

`ifdef IP_TX_ARB_PRIO_EN
   localparam logic PRIO_EN = 1'b1;
`else
   localparam logic PRIO_EN = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   ip_hdr_t          hdr_q, hdr_d;
   logic             hdr_valid_q, hdr_valid_d;
   logic             tlast_done_q, tlast_done_d;

   logic             sel_vld;
   logic [IDX_W-1:0] sel_idx;
   logic             pay_en;
   logic             tlast_fire;
   logic             hdr_fire;

   ip_tx_arb_rr_sel #(
      .N  (S_COUNT),
      .IW (IDX_W)
   ) u_rr_sel (
      .req        (s_ip_hdr_valid),
      .last_grant (last_grant_q),
      .prio_en    (PRIO_EN),
      .gnt_vld    (sel_vld),
      .gnt_idx    (sel_idx)
   );

   always_comb begin
      state_d                  = state_q;
      grant_d                  = grant_q;
      last_grant_d             = last_grant_q;
      hdr_d                    = hdr_q;
      hdr_valid_d              = hdr_valid_q;
      tlast_done_d             = tlast_done_q;
      s_ip_hdr_ready           = '0;
      s_ip_payload_axis_tready = '0;

      // Once the granted tlast has gone, the mux closes so the requester's next
      // packet cannot leak out while the header is still waiting for acceptance.
      pay_en = (state_q == ST_ACTIVE) && !tlast_done_q;

      m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_ip_payload_axis_tkeep  = s_ip_payload_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
      m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast[grant_q];
      m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser[grant_q];
      m_ip_payload_axis_tvalid = pay_en & s_ip_payload_axis_tvalid[grant_q];

      hdr_fire   = hdr_valid_q & m_ip_hdr_ready;
      tlast_fire = m_ip_payload_axis_tvalid & m_ip_payload_axis_tready & m_ip_payload_axis_tlast;

      case (state_q)
         ST_IDLE: begin
            if (sel_vld) begin
               s_ip_hdr_ready[sel_idx] = 1'b1;
               hdr_d                   = hdr_unpack(s_ip_hdr[int'(sel_idx)*HDR_W +: HDR_W]);
               hdr_valid_d             = 1'b1;
               grant_d                 = sel_idx;
               tlast_done_d            = 1'b0;
               state_d                 = ST_ACTIVE;
               // Under strict priority port 0 must not disturb the rotation of the others.
               if (!PRIO_EN || (sel_idx != '0)) last_grant_d = sel_idx;
            end
         end
         ST_ACTIVE: begin
            s_ip_payload_axis_tready[grant_q] = pay_en & m_ip_payload_axis_tready;
            if (hdr_fire) hdr_valid_d = 1'b0;
            if (tlast_fire) tlast_done_d = 1'b1;
            if ((tlast_done_q || tlast_fire) && (!hdr_valid_q || m_ip_hdr_ready)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (rst) begin
         s_ip_hdr_ready           = '0;
         s_ip_payload_axis_tready = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(S_COUNT - 1);
         hdr_valid_q  <= 1'b0;
         tlast_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         hdr_valid_q  <= hdr_valid_d;
         tlast_done_q <= tlast_done_d;
      end
      hdr_q <= hdr_d;
   end

   assign m_ip_hdr_valid = hdr_valid_q;
   assign m_ip_hdr       = hdr_pack(hdr_q);
   assign m_grant_index  = grant_q;
   assign busy           = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_ip_tx_arb.sv
// Self-checking bench for ip_tx_arb: transaction-level scoreboard plus directed literal checks.
module tb_ip_tx_arb;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int HW = 105;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     s_ip_hdr_valid;
   logic [NP-1:0]     s_ip_hdr_ready;
   logic [NP*HW-1:0]  s_ip_hdr;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*KW-1:0]  s_tkeep;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tready;
   logic [NP-1:0]     s_tlast;
   logic [NP-1:0]     s_tuser;
   logic              m_ip_hdr_valid;
   logic              m_ip_hdr_ready;
   logic [HW-1:0]     m_ip_hdr;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic              m_tuser;
   logic [1:0]        m_grant_index;
   logic              busy;

   ip_tx_arb #(.S_COUNT(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .s_ip_hdr_valid           (s_ip_hdr_valid),
      .s_ip_hdr_ready           (s_ip_hdr_ready),
      .s_ip_hdr                 (s_ip_hdr),
      .s_ip_payload_axis_tdata  (s_tdata),
      .s_ip_payload_axis_tkeep  (s_tkeep),
      .s_ip_payload_axis_tvalid (s_tvalid),
      .s_ip_payload_axis_tready (s_tready),
      .s_ip_payload_axis_tlast  (s_tlast),
      .s_ip_payload_axis_tuser  (s_tuser),
      .m_ip_hdr_valid           (m_ip_hdr_valid),
      .m_ip_hdr_ready           (m_ip_hdr_ready),
      .m_ip_hdr                 (m_ip_hdr),
      .m_ip_payload_axis_tdata  (m_tdata),
      .m_ip_payload_axis_tkeep  (m_tkeep),
      .m_ip_payload_axis_tvalid (m_tvalid),
      .m_ip_payload_axis_tready (m_tready),
      .m_ip_payload_axis_tlast  (m_tlast),
      .m_ip_payload_axis_tuser  (m_tuser),
      .m_grant_index            (m_grant_index),
      .busy                     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int num_pkts[NP];
   int len_tab[NP][64];
   bit hold_low = 0;
   bit tr_rand  = 0;
   bit hr_rand  = 0;

   // scoreboard state shared with the directed tests
   bit  open;
   int  delivered;
   int  log_q[$];

   function automatic logic [HW-1:0] mk_hdr(input int p, input int id);
      return {(p == 0), 6'(id), 2'(p), 16'(id*64 + p), 8'h40, 8'h11,
              8'hC0, 8'hA8, 8'(p), 8'(id), 8'h0A, 16'h0000, 8'(p + 1)};
   endfunction

   function automatic logic [DW-1:0] bdata(input int p, input int id, input int b);
      return {8'(p), 8'(id), 16'(b), 32'hA5A5_0000 ^ 32'(p*1000 + id*10 + b)};
   endfunction

   function automatic logic [KW-1:0] bkeep(input int id, input bit last);
      logic [KW-1:0] k;
      k = 8'hFF;
      return last ? (k >> (id % 8)) : k;
   endfunction

   function automatic int winner(input logic [NP-1:0] v, input int ptr);
`ifdef IP_TX_ARB_PRIO_EN
      if (v[0]) return 0;
`endif
      for (int k = 1; k <= NP; k++) begin
         if (v[(ptr + k) % NP]) return (ptr + k) % NP;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Source and sink driver
   initial begin
      int cur[NP];
      int hs[NP];
      int bt[NP];
      bit hf[NP];
      bit bf[NP];
      bit rs;
      bit pend;
      for (int p = 0; p < NP; p++) begin
         cur[p] = 0; hs[p] = 0; bt[p] = 0;
      end
      s_ip_hdr_valid = '0; s_ip_hdr = '0; s_tdata = '0; s_tkeep = '0;
      s_tvalid = '0; s_tlast = '0; s_tuser = '0;
      m_tready = 1'b1; m_ip_hdr_ready = 1'b1;
      forever begin
         @(negedge clk);
         rs = rst;
         for (int p = 0; p < NP; p++) begin
            hf[p] = s_ip_hdr_valid[p] && s_ip_hdr_ready[p];
            bf[p] = s_tvalid[p] && s_tready[p];
         end
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++) begin
            if (rs) begin
               cur[p] = 0; hs[p] = 0; bt[p] = 0;
            end else begin
               if (hf[p]) hs[p] = 1;
               if (bf[p]) begin
                  if (bt[p] == len_tab[p][cur[p]] - 1) begin
                     cur[p]++; hs[p] = 0; bt[p] = 0;
                  end else bt[p]++;
               end
            end
            pend = (cur[p] < num_pkts[p]);
            s_ip_hdr_valid[p]     = pend && (hs[p] == 0);
            s_ip_hdr[p*HW +: HW]  = mk_hdr(p, cur[p]);
            s_tvalid[p]           = pend;
            s_tlast[p]            = pend && (bt[p] == len_tab[p][cur[p] % 64] - 1);
            s_tdata[p*DW +: DW]   = bdata(p, cur[p], bt[p]);
            s_tkeep[p*KW +: KW]   = bkeep(cur[p], s_tlast[p]);
            s_tuser[p]            = s_tlast[p] && (cur[p] % 3 == 2);
         end
         m_tready       = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         m_ip_hdr_ready = hold_low ? 1'b0 : (hr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Scoreboard / compare process
   initial begin
      int ptr, gp, w;
      bit pdone, prev_rst, lastb;
      int mid[NP];
      int mbeat[NP];
      logic [HW-1:0] hq[$];
      logic [NP-1:0] exp_tr;
      prev_rst = 1;
      ptr = NP - 1; gp = 0; pdone = 0; open = 0; delivered = 0;
      for (int p = 0; p < NP; p++) begin mid[p] = 0; mbeat[p] = 0; end
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_hdr_ready", 128'(s_ip_hdr_ready), 128'(0));
            chk("rst_tready", 128'(s_tready), 128'(0));
            if (prev_rst) begin
               chk("rst_busy", 128'(busy), 128'(0));
               chk("rst_hdr_valid", 128'(m_ip_hdr_valid), 128'(0));
               chk("rst_grant_index", 128'(m_grant_index), 128'(0));
               chk("rst_tvalid", 128'(m_tvalid), 128'(0));
            end
            ptr = NP - 1; gp = 0; pdone = 0; open = 0; delivered = 0;
            hq.delete(); log_q.delete();
            for (int p = 0; p < NP; p++) begin mid[p] = 0; mbeat[p] = 0; end
         end else if (!open) begin
            chk("idle_busy", 128'(busy), 128'(0));
            chk("idle_hdr_valid", 128'(m_ip_hdr_valid), 128'(0));
            chk("idle_tvalid", 128'(m_tvalid), 128'(0));
            chk("idle_tready", 128'(s_tready), 128'(0));
            chk("idle_grant_index", 128'(m_grant_index), 128'(gp));
            if (|s_ip_hdr_valid) begin
               w = winner(s_ip_hdr_valid, ptr);
               chk("arb_hdr_ready", 128'(s_ip_hdr_ready), 128'(1) << w);
               open = 1; gp = w; pdone = 0;
               hq.push_back(mk_hdr(w, mid[w]));
               log_q.push_back(w);
`ifdef IP_TX_ARB_PRIO_EN
               if (w != 0) ptr = w;
`else
               ptr = w;
`endif
            end else begin
               chk("idle_no_ready", 128'(s_ip_hdr_ready), 128'(0));
            end
         end else begin
            chk("act_hdr_ready", 128'(s_ip_hdr_ready), 128'(0));
            chk("act_busy", 128'(busy), 128'(1));
            chk("act_grant_index", 128'(m_grant_index), 128'(gp));
            chk("act_hdr_valid", 128'(m_ip_hdr_valid), 128'(hq.size() != 0));
            if (hq.size() != 0) begin
               chk("act_hdr", 128'(m_ip_hdr), 128'(hq[0]));
               if (m_ip_hdr_valid && m_ip_hdr_ready) void'(hq.pop_front());
            end
            exp_tr = '0;
            exp_tr[gp] = !pdone && m_tready;
            chk("act_tready", 128'(s_tready), 128'(exp_tr));
            chk("act_tvalid", 128'(m_tvalid), 128'(!pdone && s_tvalid[gp]));
            if (m_tvalid && m_tready && !pdone) begin
               lastb = (mbeat[gp] == len_tab[gp][mid[gp]] - 1);
               chk("pay_data", 128'(m_tdata), 128'(bdata(gp, mid[gp], mbeat[gp])));
               chk("pay_keep", 128'(m_tkeep), 128'(bkeep(mid[gp], lastb)));
               chk("pay_last", 128'(m_tlast), 128'(lastb));
               chk("pay_user", 128'(m_tuser), 128'(lastb && (mid[gp] % 3 == 2)));
               if (lastb) begin
                  pdone = 1; mid[gp]++; mbeat[gp] = 0; delivered++;
               end else mbeat[gp]++;
            end
            if (pdone && hq.size() == 0) open = 0;
         end
         prev_rst = rst;
      end
   end

   task automatic cyc();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_tabs();
      for (int p = 0; p < NP; p++) begin
         num_pkts[p] = 0;
         for (int k = 0; k < 64; k++) len_tab[p][k] = 2;
      end
   endtask

   task automatic enter_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      clear_tabs();
   endtask

   task automatic leave_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int t;
      t = 0;
      while ((delivered < n || open) && t < 20000) begin
         cyc();
         t++;
      end
      chk("pkts_done", 128'(delivered), 128'(n));
      chk("arb_idle_at_end", 128'(open), 128'(0));
   endtask

   initial begin
      int t, beats;
      bit done;
      int exp6[6];
      clear_tabs();
      repeat (3) @(posedge clk);

      // T1: single 3-beat packet on port 1
      num_pkts[1] = 1; len_tab[1][0] = 3;
      leave_reset();
      cyc();
      t = 0;
      while (!(s_ip_hdr_valid[1] && s_ip_hdr_ready[1]) && t < 20) begin cyc(); t++; end
      chk("t1_hdr_accept", 128'(s_ip_hdr_ready), 128'(4'b0010));
      cyc();
      chk("t1_hdr_valid", 128'(m_ip_hdr_valid), 128'(1));
      chk("t1_grant_index", 128'(m_grant_index), 128'(1));
      chk("t1_dest_ip", 128'(m_ip_hdr[31:0]), 128'(32'h0A00_0002));
      beats = 0; done = 0; t = 0;
      while (!done && t < 50) begin
         if (m_tvalid && m_tready) begin
            beats++;
            if (m_tlast) done = 1;
         end
         if (!done) begin cyc(); t++; end
      end
      chk("t1_beats", 128'(beats), 128'(3));
      cyc();
      chk("t1_busy_drop", 128'(busy), 128'(0));

      // T2: ports 0 and 1 continuously valid, 4 packets each
      enter_reset();
      num_pkts[0] = 4; num_pkts[1] = 4;
      len_tab[0][1] = 1; len_tab[1][2] = 3; len_tab[0][3] = 4;
      leave_reset();
      wait_done(8);
      chk("t2_grant_count", 128'(log_q.size()), 128'(8));
      for (int i = 0; i < log_q.size() && i < 8; i++)
         chk("t2_grant_order", 128'(log_q[i]), 128'(i % 2));

      // T3: header held back while a 2-beat payload completes
      enter_reset();
      num_pkts[0] = 2;
      hold_low = 1;
      leave_reset();
      t = 0;
      while (log_q.size() < 1 && t < 20) begin cyc(); t++; end
      repeat (5) cyc();
      chk("t3_busy_held", 128'(busy), 128'(1));
      chk("t3_hdr_valid_held", 128'(m_ip_hdr_valid), 128'(1));
      chk("t3_no_next_payload", 128'(m_tvalid), 128'(0));
      chk("t3_no_hdr_ready", 128'(s_ip_hdr_ready), 128'(0));
      chk("t3_one_pkt_out", 128'(delivered), 128'(1));
      hold_low = 0;
      wait_done(2);

      // T4: four ports, 200 packets, random throttling on both outputs
      enter_reset();
      for (int p = 0; p < NP; p++) begin
         num_pkts[p] = 50;
         for (int k = 0; k < 50; k++) len_tab[p][k] = 1 + ((p*7 + k*3 + k/5) % 4);
      end
      tr_rand = 1; hr_rand = 1;
      leave_reset();
      wait_done(200);
      chk("t4_grant_count", 128'(log_q.size()), 128'(200));
      tr_rand = 0; hr_rand = 0;

      // T5: reset during beat 2 of a 4-beat packet
      enter_reset();
      num_pkts[0] = 1; len_tab[0][0] = 4;
      leave_reset();
      beats = 0; t = 0;
      while (beats < 2 && t < 50) begin
         cyc(); t++;
         if (m_tvalid && m_tready) beats++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      cyc();
      cyc();
      chk("t5_busy", 128'(busy), 128'(0));
      chk("t5_hdr_valid", 128'(m_ip_hdr_valid), 128'(0));
      chk("t5_grant_index", 128'(m_grant_index), 128'(0));
      chk("t5_tvalid", 128'(m_tvalid), 128'(0));
      clear_tabs();
      num_pkts[0] = 1; num_pkts[1] = 1;
      leave_reset();
      wait_done(2);
      chk("t5_order_count", 128'(log_q.size()), 128'(2));
      if (log_q.size() == 2) begin
         chk("t5_first", 128'(log_q[0]), 128'(0));
         chk("t5_second", 128'(log_q[1]), 128'(1));
      end

      // T6: ports 0 and 2 always valid
      enter_reset();
      num_pkts[0] = 4; num_pkts[2] = 2;
`ifdef IP_TX_ARB_PRIO_EN
      exp6 = '{0, 0, 0, 0, 2, 2};
`else
      exp6 = '{0, 2, 0, 2, 0, 0};
`endif
      leave_reset();
      wait_done(6);
      chk("t6_grant_count", 128'(log_q.size()), 128'(6));
      for (int i = 0; i < log_q.size() && i < 6; i++)
         chk("t6_grant_order", 128'(log_q[i]), 128'(exp6[i]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
